// File: rtl/idc_pkg.sv
// Shared opcode values, instruction field positions and FSM encoding for the
// instruction decode / fetch-control block.
package idc_pkg;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_LOAD = 6'h10;
   localparam logic [5:0] OP_MUL  = 6'h08;
   localparam logic [5:0] OP_JMP  = 6'h20;
   localparam logic [5:0] OP_JZ   = 6'h21;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RD_MSB  = 25;
   localparam int RD_LSB  = 21;
   localparam int RS1_MSB = 20;
   localparam int RS1_LSB = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_START  = 2'b00,
      ST_RUN    = 2'b01,
      ST_MSTALL = 2'b10,
      ST_HALT   = 2'b11
   } state_t;

endpackage

// File: rtl/idc_opdecode.sv
// Pure combinational field split and opcode classification of one instruction word.
module idc_opdecode
   import idc_pkg::*;
(
   input  logic [31:0] i_ins,
   output logic [5:0]  o_op,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [15:0] o_imm,
   output logic        o_is_load,
   output logic        o_is_mul,
   output logic        o_is_jmp,
   output logic        o_is_jz,
   output logic        o_is_halt
);

   assign o_op  = i_ins[OP_MSB:OP_LSB];
   assign o_rd  = i_ins[RD_MSB:RD_LSB];
   assign o_rs1 = i_ins[RS1_MSB:RS1_LSB];
   assign o_imm = i_ins[IMM_MSB:IMM_LSB];

   assign o_is_load = (o_op == OP_LOAD);
   assign o_is_mul  = (o_op == OP_MUL);
   assign o_is_jmp  = (o_op == OP_JMP);
   assign o_is_jz   = (o_op == OP_JZ);
   assign o_is_halt = (o_op == OP_HALT);

endmodule

// File: rtl/instr_decode_ctrl.sv
// Decode stage at the consumer end of program-memory fetch: issues registered bundles
// to execute and steers fetch with jump redirects and stall holds.
module instr_decode_ctrl
   import idc_pkg::*;
#(
   parameter int         MUL_CYCLES = 4,
   parameter logic [5:0] NOP_OP     = 6'd0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ins,
   input  logic [15:0] current_address,
   input  logic        zero_flag,
   output logic [15:0] jmp_loc,
   output logic        pc_mux_sel,
   output logic        stall,
   output logic        stall_pm,
   output logic        dec_valid,
   output logic [5:0]  dec_op,
   output logic [4:0]  dec_rd,
   output logic [4:0]  dec_rs1,
   output logic [15:0] dec_imm,
   output logic [15:0] dec_pc,
   output logic        halted
);

   localparam int CW = $clog2(MUL_CYCLES) + 1;

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_mul_cnt, w_mul_cnt_next;
   logic [15:0]     r_pc_q;
   logic            r_load_rd_v;
   logic [4:0]      r_load_rd;

   logic [5:0]  w_op;
   logic [4:0]  w_rd, w_rs1;
   logic [15:0] w_imm;
   logic        w_is_load, w_is_mul, w_is_jmp, w_is_jz, w_is_halt;
   logic        w_hazard, w_accept, w_bubble, w_stall, w_redirect;

   idc_opdecode u_opdecode (
      .i_ins     (ins),
      .o_op      (w_op),
      .o_rd      (w_rd),
      .o_rs1     (w_rs1),
      .o_imm     (w_imm),
      .o_is_load (w_is_load),
      .o_is_mul  (w_is_mul),
      .o_is_jmp  (w_is_jmp),
      .o_is_jz   (w_is_jz),
      .o_is_halt (w_is_halt)
   );

   assign w_hazard = r_load_rd_v && (w_rs1 == r_load_rd);

   always_comb begin
      w_state_next   = r_state;
      w_mul_cnt_next = r_mul_cnt;
      w_accept       = 1'b0;
      w_bubble       = 1'b0;
      w_stall        = 1'b0;
      w_redirect     = 1'b0;
      case (r_state)
         // First cycle after reset repeats the addr-0 word; drop it.
         ST_START: w_state_next = ST_RUN;
         ST_RUN: begin
            if (w_hazard) begin
               w_stall  = 1'b1;
               w_bubble = 1'b1;
            end else begin
               w_accept   = 1'b1;
               w_redirect = w_is_jmp || (w_is_jz && zero_flag);
               if (w_is_halt) begin
                  w_state_next = ST_HALT;
               end else if (w_is_mul && (MUL_CYCLES > 1)) begin
                  w_state_next   = ST_MSTALL;
                  w_mul_cnt_next = CW'(MUL_CYCLES - 1);
               end
            end
         end
         ST_MSTALL: begin
            w_stall        = 1'b1;
            w_mul_cnt_next = r_mul_cnt - CW'(1);
            if (r_mul_cnt <= CW'(1)) begin
               w_state_next = ST_RUN;
            end
         end
         ST_HALT: w_stall = 1'b1;
         default: w_state_next = ST_START;
      endcase
   end

   // Gate with reset so a reset pulse releases fetch in the same cycle.
   assign stall      = reset & w_stall;
   assign stall_pm   = stall;
   assign pc_mux_sel = reset & w_redirect;
   assign jmp_loc    = pc_mux_sel ? w_imm : 16'd0;
   assign halted     = reset & (r_state == ST_HALT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_START;
         r_mul_cnt   <= '0;
         r_pc_q      <= '0;
         r_load_rd_v <= 1'b0;
         r_load_rd   <= '0;
         dec_valid   <= 1'b0;
         dec_op      <= '0;
         dec_rd      <= '0;
         dec_rs1     <= '0;
         dec_imm     <= '0;
         dec_pc      <= '0;
      end else begin
         r_state   <= w_state_next;
         r_mul_cnt <= w_mul_cnt_next;
         r_pc_q    <= current_address;
         dec_valid <= w_accept | w_bubble;
         if (w_accept) begin
            dec_op      <= w_op;
            dec_rd      <= w_rd;
            dec_rs1     <= w_rs1;
            dec_imm     <= w_imm;
            dec_pc      <= r_pc_q;
            r_load_rd_v <= w_is_load;
            r_load_rd   <= w_rd;
         end else if (w_bubble) begin
            dec_op      <= NOP_OP;
            dec_rd      <= '0;
            dec_rs1     <= '0;
            dec_imm     <= '0;
            dec_pc      <= r_pc_q;
            r_load_rd_v <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Scoreboard bench: a fetch/program-memory model feeds the DUT; an architectural
// trace model predicts issues, redirects and stall-run lengths.
module tb_instr_decode_ctrl;

   localparam int         MC   = 4;
   localparam logic [5:0] NOP  = 6'h00;
   localparam logic [5:0] LOAD = 6'h10;
   localparam logic [5:0] MUL  = 6'h08;
   localparam logic [5:0] JMP  = 6'h20;
   localparam logic [5:0] JZ   = 6'h21;
   localparam logic [5:0] HALT = 6'h3F;
   localparam logic [5:0] ADD  = 6'h01;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ins;
   logic [15:0] current_address;
   logic        zero_flag;
   logic [15:0] jmp_loc;
   logic        pc_mux_sel, stall, stall_pm, dec_valid, halted;
   logic [5:0]  dec_op;
   logic [4:0]  dec_rd, dec_rs1;
   logic [15:0] dec_imm, dec_pc;

   always #5 clk = ~clk;

   instr_decode_ctrl #(.MUL_CYCLES(MC), .NOP_OP(NOP)) dut (
      .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
      .zero_flag(zero_flag), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
      .stall(stall), .stall_pm(stall_pm), .dec_valid(dec_valid), .dec_op(dec_op),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_imm(dec_imm), .dec_pc(dec_pc),
      .halted(halted)
   );

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd, rs1;
      logic [15:0] imm, pc;
      bit          bubble;
   } iss_t;

   iss_t        exp_q[$];
   logic [15:0] jq[$];
   int          sq[$];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk = 1'b0;

   logic [31:0] mem [256];
   bit          zmap [256];
   logic [15:0] fa, last_addr;

   // Fetch model: synchronous program memory, redirect/hold steered by the DUT.
   assign current_address = pc_mux_sel ? jmp_loc : (stall ? last_addr : fa);
   assign zero_flag = zmap[last_addr[7:0]];

   always @(posedge clk) begin
      if (!reset) begin
         fa        <= 16'd0;
         last_addr <= 16'd0;
         ins       <= mem[0];
      end else begin
         last_addr <= current_address;
         ins       <= mem[current_address[7:0]];
         if (!stall) fa <= current_address + 16'd1;
      end
   end

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   // Architectural trace: walk the program, predicting what execute should see.
   task automatic run_model(input int n_max, output bit halts);
      logic [15:0] pc;
      logic [31:0] w;
      bit          lv;
      logic [4:0]  lrd;
      iss_t        e;
      pc = 16'd0; lv = 1'b0; lrd = 5'd0; halts = 1'b0;
      for (int n = 0; n < n_max; n++) begin
         w = mem[pc[7:0]];
         if (lv && w[20:16] == lrd) begin
            e = '{op: NOP, rd: 5'd0, rs1: 5'd0, imm: 16'd0, pc: pc, bubble: 1'b1};
            exp_q.push_back(e);
            sq.push_back(1);
         end
         e = '{op: w[31:26], rd: w[25:21], rs1: w[20:16], imm: w[15:0], pc: pc, bubble: 1'b0};
         exp_q.push_back(e);
         lv  = (w[31:26] == LOAD);
         lrd = w[25:21];
         if (w[31:26] == MUL && MC > 1) sq.push_back(MC - 1);
         if (w[31:26] == HALT) begin
            halts = 1'b1;
            break;
         end
         if (w[31:26] == JMP || (w[31:26] == JZ && zmap[pc[7:0]])) begin
            jq.push_back(w[15:0]);
            pc = w[15:0];
         end else begin
            pc = pc + 16'd1;
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      iss_t        e;
      logic [15:0] j;
      int          s;
      int          run;
      if (chk) begin
         n_chk++;
         if (stall_pm !== stall) begin
            n_fail++;
            $display("FAIL stall_pm: got %b, need %b", stall_pm, stall);
         end
         if (dec_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (e.bubble ? (dec_op !== NOP || dec_pc !== e.pc)
                         : ({dec_op, dec_rd, dec_rs1, dec_imm, dec_pc} !==
                            {e.op, e.rd, e.rs1, e.imm, e.pc})) begin
               n_fail++;
               $display("FAIL issue: got op=%h rd=%0d rs1=%0d imm=%h pc=%h, need op=%h rd=%0d rs1=%0d imm=%h pc=%h bubble=%0d",
                        dec_op, dec_rd, dec_rs1, dec_imm, dec_pc, e.op, e.rd, e.rs1, e.imm, e.pc, e.bubble);
            end else begin
               $display("issue pc=%h op=%h%s", dec_pc, dec_op, e.bubble ? " (bubble)" : "");
            end
         end
         if (pc_mux_sel) begin
            n_chk++;
            if (stall) begin
               n_fail++;
               $display("FAIL redirect_during_stall: got stall=1, need 0");
            end
            if (jq.size() > 0) begin
               j = jq.pop_front();
               n_chk++;
               if (jmp_loc !== j) begin
                  n_fail++;
                  $display("FAIL jmp_loc: got %h, need %h", jmp_loc, j);
               end
            end else if (exp_q.size() > 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL redirect: got unexpected pc_mux_sel to %h", jmp_loc);
            end
         end
         if (stall) begin
            run++;
         end else if (run > 0) begin
            if (sq.size() > 0) begin
               s = sq.pop_front();
               n_chk++;
               if (run != s) begin
                  n_fail++;
                  $display("FAIL stall_run: got %0d cycles, need %0d", run, s);
               end
            end else if (exp_q.size() > 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL stall_run: got unexpected %0d-cycle stall", run);
            end
            run = 0;
         end
      end else begin
         run = 0;
      end
   end

   task automatic enter_reset();
      @(negedge clk);
      reset = 1'b0;
      chk   = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.delete();
      jq.delete();
      sq.delete();
      n_chk++;
      if ({jmp_loc, pc_mux_sel, stall, stall_pm, dec_valid, dec_op, dec_rd, dec_rs1,
           dec_imm, dec_pc, halted} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b stall=%b halted=%b pc=%h, need all 0",
                  dec_valid, stall, halted, dec_pc);
      end
   endtask

   task automatic run_program(input int n_max, input int halt_cycles);
      bit halts;
      int cyc;
      run_model(n_max, halts);
      @(negedge clk);
      reset = 1'b1;
      chk   = 1'b1;
      cyc   = 0;
      while (exp_q.size() > 0 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      n_chk++;
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL issue_timeout: got %0d issues outstanding, need 0", exp_q.size());
      end
      if (halts) begin
         for (int i = 0; i < halt_cycles; i++) begin
            @(negedge clk);
            n_chk++;
            if (!(halted === 1'b1 && stall === 1'b1 && dec_valid === 1'b0 && pc_mux_sel === 1'b0)) begin
               n_fail++;
               $display("FAIL halt_hold: got halted=%b stall=%b valid=%b, need 1 1 0",
                        halted, stall, dec_valid);
            end
         end
         // Reset pulse while halted must release fetch at once.
         reset = 1'b0;
         chk   = 1'b0;
         #1;
         n_chk++;
         if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_same_cycle: got stall=%b, need 0", stall);
         end
         @(negedge clk);
         n_chk++;
         if (stall !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got stall=%b halted=%b, need 0 0", stall, halted);
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         mem[a]  = enc(HALT, 5'd0, 5'd0, 16'd0);
         zmap[a] = 1'b0;
      end
      for (int a = 0; a < 4; a++) mem[a] = enc(ADD, 5'd1, 5'd2, 16'(a));
      mem[8'h04] = enc(JMP,  5'd0, 5'd0, 16'h0040);
      mem[8'h40] = enc(JZ,   5'd0, 5'd0, 16'h0080);
      mem[8'h41] = enc(JZ,   5'd0, 5'd0, 16'h0080);
      zmap[8'h41] = 1'b1;
      mem[8'h80] = enc(LOAD, 5'd3, 5'd0, 16'd0);
      mem[8'h81] = enc(ADD,  5'd5, 5'd3, 16'd0);
      mem[8'h82] = enc(LOAD, 5'd3, 5'd0, 16'd0);
      mem[8'h83] = enc(ADD,  5'd5, 5'd4, 16'd0);
      mem[8'h84] = enc(JMP,  5'd0, 5'd0, 16'h0010);
      mem[8'h10] = enc(MUL,  5'd6, 5'd1, 16'd0);
      mem[8'h11] = enc(ADD,  5'd7, 5'd1, 16'd0);
      mem[8'h12] = enc(HALT, 5'd0, 5'd0, 16'd0);
      enter_reset();
      run_program(1000, 100);

      for (int p = 0; p < 6; p++) begin
         enter_reset();
         for (int a = 0; a < 256; a++) begin
            int          r;
            logic [5:0]  op;
            logic [15:0] imm;
            r   = $urandom_range(0, 99);
            imm = 16'($urandom);
            if      (r < 15) op = LOAD;
            else if (r < 25) op = MUL;
            else if (r < 33) begin op = JMP; imm = 16'($urandom_range(0, 255)); end
            else if (r < 41) begin op = JZ;  imm = 16'($urandom_range(0, 255)); end
            else if (r < 42) op = HALT;
            else             op = 6'($urandom);
            mem[a]  = enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
            zmap[a] = 1'($urandom);
         end
         run_program(150, 10);
      end

      enter_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
